// File: rtl/multicycle_controller.sv
// Multicycle ARM control unit: sequences fetch, decode, execute, memory and writeback.
// Drives every select and write enable of the shared-memory multicycle datapath.
// The sh bus carries instr[11:4], so instr[n] is sh[n-4] throughout.
// Outputs are decoded from the current state rather than registered because the memory
// handshake (mem_ready) must steer ir_write/pc_write/mem_write in the same cycle.
module multicycle_controller #(
    parameter int unsigned ALU_CTRL_W = 4,
    parameter bit          ENABLE_RSR = 1'b1,
    parameter bit          ENABLE_BL  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            op,
    input  logic [5:0]            funct,
    input  logic [3:0]            rd,
    input  logic [7:0]            sh,
    input  logic                  cond_ex,
    input  logic                  mem_ready,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  adr_src,
    output logic                  mem_write,
    output logic                  reg_write,
    output logic                  link_select,
    output logic [1:0]            result_src,
    output logic                  alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            imm_src,
    output logic [1:0]            reg_src,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic [3:0]            flag_w,
    output logic [2:0]            shift_op,
    output logic                  register_shift,
    output logic [3:0]            state_o
);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExecR  = 4'd6,
        StExecI  = 4'd7,
        StAluWb  = 4'd8,
        StBranch = 4'd9,
        StShiftR = 4'd10
    } state_e;

    localparam logic [3:0] AluAdd = 4'b0100;

    state_e state_q, state_d;

    logic rsr_dec;    // register-shifted-register operand
    logic is_cmp;     // CMP/CMN
    logic is_tst;     // TST/TEQ
    logic dp_writes;  // data-processing result goes to the register file
    logic ir_w, pc_w, mem_w, reg_w;
    logic [3:0] flag_raw;

    assign rsr_dec   = sh[0] & ~sh[3] & ~funct[5] & (op == 2'b00);
    assign is_cmp    = (funct[4:2] == 3'b101);
    assign is_tst    = (funct[4:2] == 3'b100);
    assign dp_writes = (funct[4:3] != 2'b10);
    assign state_o   = state_q;

    // Write enables are forced low while reset is asserted, independent of the clock.
    assign ir_write  = ir_w & reset_n;
    assign pc_write  = pc_w & reset_n;
    assign mem_write = mem_w & reset_n;
    assign reg_write = reg_w & reset_n;
    assign flag_w    = flag_raw & {4{reset_n}};

    // Shift type decode: immediates rotate; LSL-free ROR #0 encodes RRX.
    always_comb begin
        if (funct[5]) begin
            shift_op = 3'd3;
        end else if (sh[7:3] == 5'd0 && !sh[0] && sh[2:1] == 2'b11) begin
            shift_op = 3'd4;
        end else begin
            shift_op = {1'b0, sh[2:1]};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = StFetch;
        case (state_q)
            StFetch:  state_d = mem_ready ? StDecode : StFetch;
            StDecode: begin
                if (!cond_ex) begin
                    state_d = StFetch;
                end else if (op == 2'b01) begin
                    state_d = StMemAdr;
                end else if (op[1]) begin
                    state_d = StBranch;
                end else if (funct[5]) begin
                    state_d = StExecI;
                end else if (rsr_dec && ENABLE_RSR) begin
                    state_d = StShiftR;
                end else begin
                    state_d = StExecR;
                end
            end
            StShiftR: state_d = StExecR;
            StExecR:  state_d = StAluWb;
            StExecI:  state_d = StAluWb;
            StMemAdr: state_d = funct[0] ? StMemRd : StMemWr;
            StMemRd:  state_d = mem_ready ? StMemWb : StMemRd;
            StMemWr:  state_d = mem_ready ? StFetch : StMemWr;
            default:  state_d = StFetch;
        endcase
    end

    // Per-state datapath controls; unlisted outputs stay 0 and the ALU defaults to ADD.
    always_comb begin
        ir_w           = 1'b0;
        pc_w           = 1'b0;
        mem_w          = 1'b0;
        reg_w          = 1'b0;
        flag_raw       = 4'b0000;
        adr_src        = 1'b0;
        link_select    = 1'b0;
        result_src     = 2'b00;
        alu_src_a      = 1'b0;
        alu_src_b      = 2'b00;
        imm_src        = 2'b00;
        reg_src        = 2'b00;
        alu_control    = ALU_CTRL_W'(AluAdd);
        register_shift = 1'b0;
        case (state_q)
            StDecode: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            StShiftR: register_shift = 1'b1;
            StExecR, StExecI: begin
                alu_src_b   = (state_q == StExecI) ? 2'b01 : 2'b00;
                alu_control = ALU_CTRL_W'(funct[4:1]);
                flag_raw    = {funct[0], funct[0], funct[0], 1'b0};
                if (is_cmp) begin
                    flag_raw = 4'b1111;
                end else if (is_tst) begin
                    flag_raw[3:1] = 3'b111;
                end
            end
            StAluWb: begin
                reg_w = dp_writes;
                pc_w  = dp_writes & (rd == 4'd15);
            end
            StMemAdr: begin
                alu_src_b = 2'b01;
                imm_src   = 2'b01;
            end
            StMemRd:  adr_src = 1'b1;
            StMemWb: begin
                result_src = 2'b01;
                reg_w      = 1'b1;
                pc_w       = (rd == 4'd15);
            end
            StMemWr: begin
                adr_src = 1'b1;
                reg_src = 2'b10;
                mem_w   = 1'b1;
            end
            StBranch: begin
                reg_src    = 2'b01;
                alu_src_b  = 2'b01;
                imm_src    = 2'b10;
                result_src = 2'b10;
                pc_w       = 1'b1;
                if (op == 2'b11 && ENABLE_BL) begin
                    reg_w       = 1'b1;
                    link_select = 1'b1;
                end
            end
            // FETCH and the unused codes 11-15 share the fetch controls.
            default: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_w       = mem_ready;
                pc_w       = mem_ready;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-cycle vector table fed through a
// scoreboard queue, plus hand sequences for the reduced-feature build and reset aborts.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [1:0] op = '0;
    logic [5:0] funct = '0;
    logic [3:0] rd = '0;
    logic [7:0] sh = '0;
    logic       cond_ex = 1'b0;
    logic       mem_ready = 1'b0;

    logic       ir_write, pc_write, adr_src, mem_write, reg_write, link_select;
    logic [1:0] result_src, alu_src_b, imm_src, reg_src;
    logic       alu_src_a, register_shift;
    logic [3:0] alu_control, flag_w, state_o;
    logic [2:0] shift_op;

    logic       d1_ir_write, d1_pc_write, d1_adr_src, d1_mem_write, d1_reg_write, d1_link_select;
    logic [1:0] d1_result_src, d1_alu_src_b, d1_imm_src, d1_reg_src;
    logic       d1_alu_src_a, d1_register_shift;
    logic [3:0] d1_alu_control, d1_flag_w, d1_state_o;
    logic [2:0] d1_shift_op;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .rd(rd), .sh(sh),
        .cond_ex(cond_ex), .mem_ready(mem_ready), .ir_write(ir_write), .pc_write(pc_write),
        .adr_src(adr_src), .mem_write(mem_write), .reg_write(reg_write),
        .link_select(link_select), .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .imm_src(imm_src), .reg_src(reg_src),
        .alu_control(alu_control), .flag_w(flag_w), .shift_op(shift_op),
        .register_shift(register_shift), .state_o(state_o)
    );

    multicycle_controller #(.ALU_CTRL_W(4), .ENABLE_RSR(1'b0), .ENABLE_BL(1'b0)) dut_min (
        .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .rd(rd), .sh(sh),
        .cond_ex(cond_ex), .mem_ready(mem_ready), .ir_write(d1_ir_write),
        .pc_write(d1_pc_write), .adr_src(d1_adr_src), .mem_write(d1_mem_write),
        .reg_write(d1_reg_write), .link_select(d1_link_select), .result_src(d1_result_src),
        .alu_src_a(d1_alu_src_a), .alu_src_b(d1_alu_src_b), .imm_src(d1_imm_src),
        .reg_src(d1_reg_src), .alu_control(d1_alu_control), .flag_w(d1_flag_w),
        .shift_op(d1_shift_op), .register_shift(d1_register_shift), .state_o(d1_state_o)
    );

    // {ir, pc, mem, reg, link}
    logic [4:0] we_act, d1_we_act;
    // {adr_src, result_src, alu_src_a, alu_src_b, imm_src, reg_src}
    logic [9:0] sel_act;
    logic [3:0] so_act;
    assign we_act    = {ir_write, pc_write, mem_write, reg_write, link_select};
    assign d1_we_act = {d1_ir_write, d1_pc_write, d1_mem_write, d1_reg_write, d1_link_select};
    assign sel_act   = {adr_src, result_src, alu_src_a, alu_src_b, imm_src, reg_src};
    assign so_act    = {shift_op, register_shift};

    localparam logic [9:0] SF  = 10'b0_10_1_10_00_00;  // FETCH
    localparam logic [9:0] SD  = 10'b0_00_1_10_00_00;  // DECODE
    localparam logic [9:0] SI  = 10'b0_00_0_01_00_00;  // EXECI
    localparam logic [9:0] S0  = 10'b0_00_0_00_00_00;  // EXECR / ALUWB / SHIFTR
    localparam logic [9:0] SMA = 10'b0_00_0_01_01_00;  // MEMADR
    localparam logic [9:0] SRD = 10'b1_00_0_00_00_00;  // MEMRD
    localparam logic [9:0] SWB = 10'b0_01_0_00_00_00;  // MEMWB
    localparam logic [9:0] SWR = 10'b1_00_0_00_00_10;  // MEMWR
    localparam logic [9:0] SBR = 10'b0_10_0_01_10_01;  // BRANCH

    typedef struct {
        logic [1:0] op;  logic [5:0] funct; logic [3:0] rd; logic [7:0] sh;
        logic cnd; logic rdy;
        logic [3:0] st; logic [4:0] we; logic [3:0] fw; logic [3:0] ac;
        logic [9:0] sel; logic [3:0] so;
    } vec_t;
    typedef struct {
        logic [3:0] st; logic [4:0] we; logic [3:0] fw; logic [3:0] ac;
        logic [9:0] sel; logic [3:0] so;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    logic [1:0] c_op;
    logic [5:0] c_funct;
    logic [3:0] c_rd;
    logic [7:0] c_sh;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic ins(input logic [1:0] o, input logic [5:0] f, input logic [3:0] r,
                       input logic [7:0] s);
        c_op = o; c_funct = f; c_rd = r; c_sh = s;
    endtask

    task automatic row(input logic [3:0] st, input logic [4:0] we, input logic [3:0] fw,
                       input logic [3:0] ac, input logic [9:0] sel, input logic [3:0] so,
                       input logic rdy, input logic cnd);
        tbl.push_back('{c_op, c_funct, c_rd, c_sh, cnd, rdy, st, we, fw, ac, sel, so});
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        logic [3:0] st_seq[5];

        // Async reset before any clock edge, with mem_ready high to expose ungated enables.
        #1 reset_n = 1'b0;
        mem_ready = 1'b1;
        #3;
        check("reset state", 32'(state_o), 32'd0);
        check("reset enables", 32'({ir_write, pc_write, mem_write, reg_write}), 32'd0);
        check("reset flag_w", 32'(flag_w), 32'd0);
        do_reset();

        // ADD R1,R2,#5
        ins(2'b00, 6'b101000, 4'd1, 8'h00);
        row(4'd0, 5'b11000, 4'h0, 4'h4, SF, 4'b0110, 1'b1, 1'b1);
        row(4'd1, 5'b00000, 4'h0, 4'h4, SD, 4'b0110, 1'b1, 1'b1);
        row(4'd7, 5'b00000, 4'h0, 4'h4, SI, 4'b0110, 1'b1, 1'b1);
        row(4'd8, 5'b00010, 4'h0, 4'h4, S0, 4'b0110, 1'b1, 1'b1);
        // LDR R3,[R4,#8] with a fetch wait and three MEMRD wait cycles
        ins(2'b01, 6'b011001, 4'd3, 8'h00);
        row(4'd0, 5'b00000, 4'h0, 4'h4, SF,  4'b0000, 1'b0, 1'b1);
        row(4'd0, 5'b11000, 4'h0, 4'h4, SF,  4'b0000, 1'b1, 1'b1);
        row(4'd1, 5'b00000, 4'h0, 4'h4, SD,  4'b0000, 1'b1, 1'b1);
        row(4'd2, 5'b00000, 4'h0, 4'h4, SMA, 4'b0000, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) row(4'd3, 5'b00000, 4'h0, 4'h4, SRD, 4'b0000, 1'b0, 1'b1);
        row(4'd3, 5'b00000, 4'h0, 4'h4, SRD, 4'b0000, 1'b1, 1'b1);
        row(4'd4, 5'b00010, 4'h0, 4'h4, SWB, 4'b0000, 1'b1, 1'b1);
        // CMP R1,R2
        ins(2'b00, 6'b010101, 4'd0, 8'h00);
        row(4'd0, 5'b11000, 4'h0, 4'h4, SF, 4'b0000, 1'b1, 1'b1);
        row(4'd1, 5'b00000, 4'h0, 4'h4, SD, 4'b0000, 1'b1, 1'b1);
        row(4'd6, 5'b00000, 4'hF, 4'hA, S0, 4'b0000, 1'b1, 1'b1);
        row(4'd8, 5'b00000, 4'h0, 4'h4, S0, 4'b0000, 1'b1, 1'b1);
        // ADDS R15,R1,R2: flags and PC write from ALUWB
        ins(2'b00, 6'b001001, 4'd15, 8'h00);
        row(4'd0, 5'b11000, 4'h0, 4'h4, SF, 4'b0000, 1'b1, 1'b1);
        row(4'd1, 5'b00000, 4'h0, 4'h4, SD, 4'b0000, 1'b1, 1'b1);
        row(4'd6, 5'b00000, 4'hE, 4'h4, S0, 4'b0000, 1'b1, 1'b1);
        row(4'd8, 5'b01010, 4'h0, 4'h4, S0, 4'b0000, 1'b1, 1'b1);
        // ADD R0,R1,R2,LSL R3 -> SHIFTR
        ins(2'b00, 6'b001000, 4'd0, 8'h31);
        row(4'd0,  5'b11000, 4'h0, 4'h4, SF, 4'b0000, 1'b1, 1'b1);
        row(4'd1,  5'b00000, 4'h0, 4'h4, SD, 4'b0000, 1'b1, 1'b1);
        row(4'd10, 5'b00000, 4'h0, 4'h4, S0, 4'b0001, 1'b1, 1'b1);
        row(4'd6,  5'b00000, 4'h0, 4'h4, S0, 4'b0000, 1'b1, 1'b1);
        row(4'd8,  5'b00010, 4'h0, 4'h4, S0, 4'b0000, 1'b1, 1'b1);
        // BL taken, then BL annulled in DECODE
        ins(2'b11, 6'b110000, 4'd0, 8'h00);
        row(4'd0, 5'b11000, 4'h0, 4'h4, SF,  4'b0110, 1'b1, 1'b1);
        row(4'd1, 5'b00000, 4'h0, 4'h4, SD,  4'b0110, 1'b1, 1'b1);
        row(4'd9, 5'b01011, 4'h0, 4'h4, SBR, 4'b0110, 1'b1, 1'b1);
        row(4'd0, 5'b11000, 4'h0, 4'h4, SF,  4'b0110, 1'b1, 1'b1);
        row(4'd1, 5'b00000, 4'h0, 4'h4, SD,  4'b0110, 1'b1, 1'b0);
        // STR R5,[R6,#4] with two MEMWR wait cycles
        ins(2'b01, 6'b011000, 4'd5, 8'h00);
        row(4'd0, 5'b11000, 4'h0, 4'h4, SF,  4'b0000, 1'b1, 1'b1);
        row(4'd1, 5'b00000, 4'h0, 4'h4, SD,  4'b0000, 1'b1, 1'b1);
        row(4'd2, 5'b00000, 4'h0, 4'h4, SMA, 4'b0000, 1'b1, 1'b1);
        row(4'd5, 5'b00100, 4'h0, 4'h4, SWR, 4'b0000, 1'b0, 1'b1);
        row(4'd5, 5'b00100, 4'h0, 4'h4, SWR, 4'b0000, 1'b0, 1'b1);
        row(4'd5, 5'b00100, 4'h0, 4'h4, SWR, 4'b0000, 1'b1, 1'b1);
        row(4'd0, 5'b11000, 4'h0, 4'h4, SF,  4'b0000, 1'b1, 1'b1);

        foreach (tbl[i]) begin
            op = tbl[i].op; funct = tbl[i].funct; rd = tbl[i].rd; sh = tbl[i].sh;
            cond_ex = tbl[i].cnd; mem_ready = tbl[i].rdy;
            sb.push_back('{tbl[i].st, tbl[i].we, tbl[i].fw, tbl[i].ac, tbl[i].sel, tbl[i].so});
            @(negedge clk);
            e = sb.pop_front();
            check($sformatf("row%0d state", i), 32'(state_o), 32'(e.st));
            check($sformatf("row%0d enables", i), 32'(we_act), 32'(e.we));
            check($sformatf("row%0d flag_w", i), 32'(flag_w), 32'(e.fw));
            check($sformatf("row%0d alu_control", i), 32'(alu_control), 32'(e.ac));
            check($sformatf("row%0d selects", i), 32'(sel_act), 32'(e.sel));
            check($sformatf("row%0d shift", i), 32'(so_act), 32'(e.so));
            @(posedge clk);
            #1;
        end

        // ENABLE_RSR=0: reg-shifted-reg goes straight to EXECR
        do_reset();
        ins(2'b00, 6'b001000, 4'd0, 8'h31);
        op = c_op; funct = c_funct; rd = c_rd; sh = c_sh;
        cond_ex = 1'b1; mem_ready = 1'b1;
        st_seq = '{4'd0, 4'd1, 4'd6, 4'd8, 4'd0};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("no-rsr step%0d state", k), 32'(d1_state_o), 32'(st_seq[k]));
            check($sformatf("no-rsr step%0d regshift", k), 32'(d1_register_shift), 32'd0);
            @(posedge clk);
            #1;
        end

        // ENABLE_BL=0: BL branches without writing the link register
        do_reset();
        op = 2'b11; funct = 6'b110000; rd = 4'd0; sh = 8'h00;
        cond_ex = 1'b1; mem_ready = 1'b1;
        st_seq = '{4'd0, 4'd1, 4'd9, 4'd0, 4'd1};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("no-bl step%0d state", k), 32'(d1_state_o), 32'(st_seq[k]));
            if (k == 2) check("no-bl branch enables", 32'(d1_we_act), 32'b01000);
            @(posedge clk);
            #1;
        end

        // Reset asserted off-edge during a MEMWR wait
        do_reset();
        op = 2'b01; funct = 6'b011000; rd = 4'd5; sh = 8'h00;
        cond_ex = 1'b1; mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("memwr wait state", 32'(state_o), 32'd5);
        check("memwr wait mem_write", 32'(mem_write), 32'd1);
        #2;
        reset_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("abort state", 32'(state_o), 32'd0);
        check("abort enables", 32'({ir_write, pc_write, mem_write, reg_write}), 32'd0);
        check("abort flag_w", 32'(flag_w), 32'd0);
        @(posedge clk); #1;
        check("held reset state", 32'(state_o), 32'd0);
        check("held reset ir_write", 32'(ir_write), 32'd0);
        reset_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
